// File: rtl/conv_dat_addr_gen.sv
// Feature-buffer read address sequencer for the convolution engine: walks
// chout > stripe > chin > ky > kx > pixel. Kernel dilation via CONV_DAT_DILATION_EN.
module conv_dat_addr_gen #(
    parameter int TOUT     = 8,
    parameter int W_H      = 12,
    parameter int W_W      = 12,
    parameter int W_CH     = 12,
    parameter int TIN_LOG2 = 3,
    parameter int W_K      = 4,
    parameter int W_S      = 3,
    parameter int W_P      = 3,
    parameter int RD_LAT   = 3,
    localparam int LOG2_TOUT = $clog2(TOUT)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        abort,
    input  logic [W_P-1:0]              pad_up,
    input  logic [W_P-1:0]              pad_left,
    input  logic [W_S-1:0]              Sx,
    input  logic [W_S-1:0]              Sy,
    input  logic [W_K-1:0]              Kx,
    input  logic [W_K-1:0]              Ky,
`ifdef CONV_DAT_DILATION_EN
    input  logic [W_K-1:0]              Dx,
    input  logic [W_K-1:0]              Dy,
`endif
    input  logic [W_H-1:0]              Hin,
    input  logic [W_W-1:0]              Win,
    input  logic [W_H-1:0]              Hout,
    input  logic [W_W-1:0]              Wout,
    input  logic [W_H+W_W-1:0]          Hout_x_Wout,
    input  logic [W_CH-TIN_LOG2-1:0]    CHin_div_Tin,
    input  logic [W_CH-LOG2_TOUT-1:0]   CHout_div_Tout,
    output logic                        busy,
    output logic                        done,
    output logic                        feature_vld,
    input  logic                        feature_rdy,
    output logic [W_H:0]                feature_hin,
    output logic [W_W:0]                feature_win,
    output logic [W_CH-1:0]             feature_chin,
    output logic                        feature_pad,
    output logic                        chinkykx_max_comb,
    output logic                        wout_loop_end_comb,
    output logic                        chinkykx_max,
    output logic                        wout_loop_start,
    output logic                        wout_loop_end,
    output logic                        chinkykxwout_loop_end
);

    localparam int HWW = W_H + W_W;
    localparam int NSW = HWW - LOG2_TOUT;
    localparam int CIW = W_CH - TIN_LOG2;
    localparam int COW = W_CH - LOG2_TOUT;
    localparam int AWH = W_H + W_S + 2*W_K + 2;
    localparam int AWW = W_W + W_S + 2*W_K + 2;

    typedef enum logic {S_IDLE, S_RUN} state_t;
    state_t state_q;

    logic                 done_q;
    logic [W_P-1:0]       pad_up_q, pad_left_q;
    logic [W_S-1:0]       sx_q, sy_q;
    logic [W_K-1:0]       kx_n_q, ky_n_q;
    logic [W_H-1:0]       hin_n_q, hout_q;
    logic [W_W-1:0]       win_n_q, wout_q;
    logic [CIW-1:0]       chin_n_q;
    logic [COW-1:0]       chout_n_q;
    logic [NSW-1:0]       ns_m1_q;
    logic [LOG2_TOUT-1:0] last_m1_q;

    logic [LOG2_TOUT-1:0] pp_q;
    logic [W_K-1:0]       kx_q, ky_q;
    logic [CIW-1:0]       chin_q;
    logic [NSW-1:0]       p_q;
    logic [COW-1:0]       chout_q;
    logic [W_W-1:0]       w_q, rw_q, w_inc_d;
    logic [W_H-1:0]       h_q, rh_q, h_inc_d;

    logic                 hs, pp_last, kx_last, ky_last, chin_last, p_last, chout_last, ckm;
    logic                 zero_cfg;
    logic [HWW-1:0]       hw_m1;
    logic [LOG2_TOUT-1:0] pp_max;
    logic [3:0]           sb_comb;
    logic [3:0]           pipe_q [RD_LAT];

    assign busy = (state_q == S_RUN);
    assign done = done_q;
    assign hs   = busy & feature_rdy;

    assign zero_cfg = (Kx == '0) | (Ky == '0) | (CHin_div_Tin == '0) |
                      (CHout_div_Tout == '0) | (Hout_x_Wout == '0);
    assign hw_m1    = Hout_x_Wout - HWW'(1);

    assign pp_max     = (p_q == ns_m1_q) ? last_m1_q : LOG2_TOUT'(TOUT - 1);
    assign pp_last    = (pp_q == pp_max);
    assign kx_last    = (kx_q == kx_n_q - W_K'(1));
    assign ky_last    = (ky_q == ky_n_q - W_K'(1));
    assign chin_last  = (chin_q == chin_n_q - CIW'(1));
    assign p_last     = (p_q == ns_m1_q);
    assign chout_last = (chout_q == chout_n_q - COW'(1));
    assign ckm        = kx_last & ky_last & chin_last;

    // Row-major successor of (w, h); h wraps only past the final pixel of the map.
    always_comb begin
        w_inc_d = w_q + W_W'(1);
        h_inc_d = h_q;
        if (w_q == wout_q - W_W'(1)) begin
            w_inc_d = '0;
            h_inc_d = (h_q == hout_q - W_H'(1)) ? '0 : h_q + W_H'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            done_q     <= 1'b0;
            pad_up_q   <= '0;
            pad_left_q <= '0;
            sx_q       <= '0;
            sy_q       <= '0;
            kx_n_q     <= '0;
            ky_n_q     <= '0;
            hin_n_q    <= '0;
            win_n_q    <= '0;
            hout_q     <= '0;
            wout_q     <= '0;
            chin_n_q   <= '0;
            chout_n_q  <= '0;
            ns_m1_q    <= '0;
            last_m1_q  <= '0;
            pp_q       <= '0;
            kx_q       <= '0;
            ky_q       <= '0;
            chin_q     <= '0;
            p_q        <= '0;
            chout_q    <= '0;
            w_q        <= '0;
            h_q        <= '0;
            rw_q       <= '0;
            rh_q       <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        pad_up_q   <= pad_up;
                        pad_left_q <= pad_left;
                        sx_q       <= Sx;
                        sy_q       <= Sy;
                        kx_n_q     <= Kx;
                        ky_n_q     <= Ky;
                        hin_n_q    <= Hin;
                        win_n_q    <= Win;
                        hout_q     <= Hout;
                        wout_q     <= Wout;
                        chin_n_q   <= CHin_div_Tin;
                        chout_n_q  <= CHout_div_Tout;
                        ns_m1_q    <= hw_m1[HWW-1:LOG2_TOUT];
                        last_m1_q  <= hw_m1[LOG2_TOUT-1:0];
                        if (zero_cfg) done_q  <= 1'b1;
                        else          state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                        pp_q    <= '0;
                        kx_q    <= '0;
                        ky_q    <= '0;
                        chin_q  <= '0;
                        p_q     <= '0;
                        chout_q <= '0;
                        w_q     <= '0;
                        h_q     <= '0;
                        rw_q    <= '0;
                        rh_q    <= '0;
                    end else if (feature_rdy) begin
                        if (!pp_last) begin
                            pp_q <= pp_q + LOG2_TOUT'(1);
                            w_q  <= w_inc_d;
                            h_q  <= h_inc_d;
                        end else begin
                            pp_q <= '0;
                            if (!ckm) begin
                                w_q <= rw_q;
                                h_q <= rh_q;
                            end else if (!p_last) begin
                                w_q  <= w_inc_d;
                                h_q  <= h_inc_d;
                                rw_q <= w_inc_d;
                                rh_q <= h_inc_d;
                            end else begin
                                w_q  <= '0;
                                h_q  <= '0;
                                rw_q <= '0;
                                rh_q <= '0;
                            end
                            if (!kx_last) kx_q <= kx_q + W_K'(1);
                            else begin
                                kx_q <= '0;
                                if (!ky_last) ky_q <= ky_q + W_K'(1);
                                else begin
                                    ky_q <= '0;
                                    if (!chin_last) chin_q <= chin_q + CIW'(1);
                                    else begin
                                        chin_q <= '0;
                                        if (!p_last) p_q <= p_q + NSW'(1);
                                        else begin
                                            p_q <= '0;
                                            if (!chout_last) chout_q <= chout_q + COW'(1);
                                            else begin
                                                chout_q <= '0;
                                                state_q <= S_IDLE;
                                                done_q  <= 1'b1;
                                            end
                                        end
                                    end
                                end
                            end
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    logic [AWH-1:0]        ky_term;
    logic [AWW-1:0]        kx_term;
    logic signed [AWH-1:0] hin_full, hin_lim;
    logic signed [AWW-1:0] win_full, win_lim;

`ifdef CONV_DAT_DILATION_EN
    logic [W_K-1:0] dx_q, dy_q, dx_eff, dy_eff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dx_q <= '0;
            dy_q <= '0;
        end else if (start && !busy) begin
            dx_q <= Dx;
            dy_q <= Dy;
        end
    end

    assign dx_eff  = (dx_q == '0) ? W_K'(1) : dx_q;
    assign dy_eff  = (dy_q == '0) ? W_K'(1) : dy_q;
    assign ky_term = AWH'(ky_q) * AWH'(dy_eff);
    assign kx_term = AWW'(kx_q) * AWW'(dx_eff);
`else
    assign ky_term = AWH'(ky_q);
    assign kx_term = AWW'(kx_q);
`endif

    assign hin_full = AWH'(h_q) * AWH'(sy_q) + ky_term - AWH'(pad_up_q);
    assign win_full = AWW'(w_q) * AWW'(sx_q) + kx_term - AWW'(pad_left_q);
    assign hin_lim  = AWH'(hin_n_q);
    assign win_lim  = AWW'(win_n_q);

    assign feature_vld  = busy;
    assign feature_hin  = busy ? hin_full[W_H:0] : '0;
    assign feature_win  = busy ? win_full[W_W:0] : '0;
    assign feature_chin = busy ? W_CH'(chin_q) : '0;
    assign feature_pad  = busy & ((hin_full < 0) | (hin_full >= hin_lim) |
                                  (win_full < 0) | (win_full >= win_lim));

    assign chinkykx_max_comb  = busy & ckm;
    assign wout_loop_end_comb = hs & pp_last;
    assign sb_comb = {chinkykx_max_comb, hs & (pp_q == '0), wout_loop_end_comb,
                      wout_loop_end_comb & ckm};

    // Sideband delay line tracks buffer read latency, free-running regardless of rdy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
        end else if (busy && abort) begin
            for (int unsigned i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= sb_comb;
            for (int unsigned i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign chinkykx_max          = pipe_q[RD_LAT-1][3];
    assign wout_loop_start       = pipe_q[RD_LAT-1][2];
    assign wout_loop_end         = pipe_q[RD_LAT-1][1];
    assign chinkykxwout_loop_end = pipe_q[RD_LAT-1][0];

endmodule

// File: tb/tb_conv_dat_addr_gen.sv
// Directed bench for conv_dat_addr_gen: loop-nest reference sequence, sideband
// history, abort, zero-size and ignored-start cases.
module tb_conv_dat_addr_gen;

    localparam int TOUT = 8;
    localparam int W_H = 12, W_W = 12, W_CH = 12, TIN_LOG2 = 3;
    localparam int W_K = 4, W_S = 3, W_P = 3, RD_LAT = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start, abort, feature_rdy;
    logic [2:0]  pad_up, pad_left, Sx, Sy;
    logic [3:0]  Kx, Ky;
`ifdef CONV_DAT_DILATION_EN
    logic [3:0]  Dx, Dy;
`endif
    logic [11:0] Hin, Win, Hout, Wout;
    logic [23:0] Hout_x_Wout;
    logic [8:0]  CHin_div_Tin, CHout_div_Tout;
    logic        busy, done, feature_vld, feature_pad;
    logic [12:0] feature_hin, feature_win;
    logic [11:0] feature_chin;
    logic        chinkykx_max_comb, wout_loop_end_comb;
    logic        chinkykx_max, wout_loop_start, wout_loop_end, chinkykxwout_loop_end;

    conv_dat_addr_gen #(.TOUT(TOUT), .W_H(W_H), .W_W(W_W), .W_CH(W_CH), .TIN_LOG2(TIN_LOG2),
                        .W_K(W_K), .W_S(W_S), .W_P(W_P), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .pad_up(pad_up), .pad_left(pad_left), .Sx(Sx), .Sy(Sy), .Kx(Kx), .Ky(Ky),
`ifdef CONV_DAT_DILATION_EN
        .Dx(Dx), .Dy(Dy),
`endif
        .Hin(Hin), .Win(Win), .Hout(Hout), .Wout(Wout), .Hout_x_Wout(Hout_x_Wout),
        .CHin_div_Tin(CHin_div_Tin), .CHout_div_Tout(CHout_div_Tout),
        .busy(busy), .done(done), .feature_vld(feature_vld), .feature_rdy(feature_rdy),
        .feature_hin(feature_hin), .feature_win(feature_win), .feature_chin(feature_chin),
        .feature_pad(feature_pad), .chinkykx_max_comb(chinkykx_max_comb),
        .wout_loop_end_comb(wout_loop_end_comb), .chinkykx_max(chinkykx_max),
        .wout_loop_start(wout_loop_start), .wout_loop_end(wout_loop_end),
        .chinkykxwout_loop_end(chinkykxwout_loop_end)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int c_pu, c_pl, c_sx, c_sy, c_kx, c_ky, c_dx, c_dy;
    int c_hin, c_win, c_hout, c_wout, c_chin, c_chout;

    int q_h[$], q_w[$], q_c[$];
    bit q_pad[$], q_ppl[$], q_pp0[$], q_ckm[$];
    logic [3:0] hist[$];

    bit m_busy = 1'b0;
    bit m_done = 1'b0;
    int m_k = 0;
    int hs_cnt, wle_cnt;

    // Reference request list straight from the loop nest (pixel = stripe*TOUT + pp).
    task automatic gen();
        int hw, ns, len, idx, h, w, hi, wi, dx, dy;
        q_h.delete(); q_w.delete(); q_c.delete();
        q_pad.delete(); q_ppl.delete(); q_pp0.delete(); q_ckm.delete();
`ifdef CONV_DAT_DILATION_EN
        dx = (c_dx == 0) ? 1 : c_dx;
        dy = (c_dy == 0) ? 1 : c_dy;
`else
        dx = 1;
        dy = 1;
`endif
        hw = c_hout * c_wout;
        ns = (hw + TOUT - 1) / TOUT;
        if (c_kx == 0 || c_ky == 0 || c_chin == 0 || c_chout == 0) ns = 0;
        for (int co = 0; co < c_chout; co++)
            for (int s = 0; s < ns; s++) begin
                len = (s == ns - 1) ? hw - s * TOUT : TOUT;
                for (int ci = 0; ci < c_chin; ci++)
                    for (int ky = 0; ky < c_ky; ky++)
                        for (int kx = 0; kx < c_kx; kx++)
                            for (int pp = 0; pp < len; pp++) begin
                                idx = s * TOUT + pp;
                                h = idx / c_wout;
                                w = idx % c_wout;
                                hi = h * c_sy - c_pu + ky * dy;
                                wi = w * c_sx - c_pl + kx * dx;
                                q_h.push_back(hi);
                                q_w.push_back(wi);
                                q_c.push_back(ci);
                                q_pad.push_back(hi < 0 || hi >= c_hin || wi < 0 || wi >= c_win);
                                q_ppl.push_back(pp == len - 1);
                                q_pp0.push_back(pp == 0);
                                q_ckm.push_back(ci == c_chin - 1 && ky == c_ky - 1 && kx == c_kx - 1);
                            end
            end
    endtask

    task automatic apply_cfg();
        pad_up = 3'(c_pu); pad_left = 3'(c_pl); Sx = 3'(c_sx); Sy = 3'(c_sy);
        Kx = 4'(c_kx); Ky = 4'(c_ky);
`ifdef CONV_DAT_DILATION_EN
        Dx = 4'(c_dx); Dy = 4'(c_dy);
`endif
        Hin = 12'(c_hin); Win = 12'(c_win); Hout = 12'(c_hout); Wout = 12'(c_wout);
        Hout_x_Wout = 24'(c_hout * c_wout);
        CHin_div_Tin = 9'(c_chin); CHout_div_Tout = 9'(c_chout);
    endtask

    // Entered and left 1 time unit after a rising edge.
    task automatic do_cycle(input bit r, input bit ab, input bit st);
        logic [3:0]  e_sb, e_dl;
        logic [12:0] eh, ew;
        feature_rdy = r; abort = ab; start = st;
        #1;
        chk("busy", busy, m_busy);
        chk("vld", feature_vld, m_busy);
        chk("done", done, m_done);
        e_sb = '0;
        eh = '0;
        ew = '0;
        if (m_busy) begin
            eh = 13'(q_h[m_k]);
            ew = 13'(q_w[m_k]);
            chk("chin", feature_chin, q_c[m_k]);
            chk("pad", feature_pad, q_pad[m_k]);
            e_sb = {q_ckm[m_k], r & q_pp0[m_k], r & q_ppl[m_k], r & q_ppl[m_k] & q_ckm[m_k]};
        end else begin
            chk("idle_pad", feature_pad, 0);
        end
        chk("hin", feature_hin, eh);
        chk("win", feature_win, ew);
        chk("ckm_comb", chinkykx_max_comb, e_sb[3]);
        chk("wle_comb", wout_loop_end_comb, e_sb[1]);
        e_dl = (hist.size() >= RD_LAT) ? hist[hist.size() - RD_LAT] : 4'b0;
        chk("dly_ckm", chinkykx_max, e_dl[3]);
        chk("dly_wls", wout_loop_start, e_dl[2]);
        chk("dly_wle", wout_loop_end, e_dl[1]);
        chk("dly_ckwle", chinkykxwout_loop_end, e_dl[0]);
        hist.push_back(e_sb);
        if (feature_vld && feature_rdy && !abort) hs_cnt++;
        if (wout_loop_end) wle_cnt++;
        @(posedge clk);
        #1;
        m_done = 1'b0;
        if (st && !m_busy) begin
            if (q_h.size() == 0) m_done = 1'b1;
            else begin
                m_busy = 1'b1;
                m_k = 0;
            end
        end else if (m_busy && ab) begin
            m_busy = 1'b0;
            for (int j = 0; j < RD_LAT && j < hist.size(); j++) hist[hist.size() - 1 - j] = '0;
        end else if (m_busy && r) begin
            m_k++;
            if (m_k == q_h.size()) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end
    endtask

    task automatic run_job(input bit rnd, input int abort_at, input bit hold,
                           input logic [12:0] f_h, input logic [12:0] f_w);
        bit r, ab, st;
        gen();
        apply_cfg();
        hs_cnt = 0;
        wle_cnt = 0;
        do_cycle(1'b1, 1'b0, 1'b1);
        chk("first_hin", feature_hin, f_h);
        chk("first_win", feature_win, f_w);
        for (int c = 0; c < 4000 && m_busy; c++) begin
            r  = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            ab = (m_k == abort_at);
            st = hold && m_k >= 10 && m_k < 20;
            if (st) begin
                Kx = 4'd1;
                CHin_div_Tin = 9'd0;
            end
            do_cycle(r, ab, st);
        end
        for (int c = 0; c < RD_LAT + 2; c++) do_cycle(1'b1, 1'b0, 1'b0);
        chk("end_busy", busy, 0);
    endtask

    initial begin
        start = 1'b0; abort = 1'b0; feature_rdy = 1'b0;
        c_pu = 1; c_pl = 1; c_sx = 1; c_sy = 1; c_kx = 3; c_ky = 3; c_dx = 1; c_dy = 1;
        c_hin = 4; c_win = 4; c_hout = 4; c_wout = 4; c_chin = 2; c_chout = 1;
        apply_cfg();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_vld", feature_vld, 0);
        chk("rst_hin", feature_hin, 0);
        chk("rst_win", feature_win, 0);
        chk("rst_pad", feature_pad, 0);
        chk("rst_sb", {chinkykx_max, wout_loop_start, wout_loop_end, chinkykxwout_loop_end}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic 3x3, rdy held high, with a start pulse train mid-job that must be ignored.
        run_job(1'b0, -1, 1'b1, 13'h1FFF, 13'h1FFF);
        chk("basic_count", hs_cnt, 288);

        // Partial last stripe: 10 pixels -> stripes of 8 and 2; Sx=2 gives right-edge padding.
        c_pu = 0; c_pl = 0; c_sx = 2; c_sy = 1; c_kx = 2; c_ky = 1;
        c_hin = 2; c_win = 9; c_hout = 2; c_wout = 5; c_chin = 1; c_chout = 2;
        run_job(1'b0, -1, 1'b0, 13'h0000, 13'h0000);
        chk("partial_count", hs_cnt, 40);
        chk("partial_wle", wle_cnt, 8);

        // Basic 3x3 under random backpressure.
        c_pu = 1; c_pl = 1; c_sx = 1; c_sy = 1; c_kx = 3; c_ky = 3;
        c_hin = 4; c_win = 4; c_hout = 4; c_wout = 4; c_chin = 2; c_chout = 1;
        run_job(1'b1, -1, 1'b0, 13'h1FFF, 13'h1FFF);
        chk("bp_count", hs_cnt, 288);

        // Abort at request 50, then a fresh job restarts from (-1,-1).
        run_job(1'b0, 50, 1'b0, 13'h1FFF, 13'h1FFF);
        chk("abort_count", hs_cnt, 50);
        run_job(1'b0, -1, 1'b0, 13'h1FFF, 13'h1FFF);
        chk("restart_count", hs_cnt, 288);

        // Zero-size job.
        c_chin = 0;
        run_job(1'b0, -1, 1'b0, 13'h0000, 13'h0000);
        chk("zero_count", hs_cnt, 0);

`ifdef CONV_DAT_DILATION_EN
        c_pu = 2; c_pl = 2; c_kx = 3; c_ky = 3; c_dx = 2; c_dy = 2;
        c_hin = 4; c_win = 4; c_hout = 2; c_wout = 2; c_chin = 1; c_chout = 1;
        run_job(1'b0, -1, 1'b0, 13'h1FFE, 13'h1FFE);
        chk("dil_count", hs_cnt, 36);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
